// File: rtl/ads131a0x_pkg.sv
// ads131a0x_pkg: shared states, command/CRC constants and the CRC-CCITT bit step.
package ads131a0x_pkg;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE} state_t;
    localparam logic [15:0] NULL_CMD = 16'h0000;
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam int SAMPLE_BITS = 24;
    localparam int MAX_CH = 4;
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        return {crc[14:0], 1'b0} ^ ((crc[15] ^ b) ? CRC_POLY : 16'h0000);
    endfunction
endpackage

// File: rtl/ads131a0x_frame_reader_if.sv
// ads131a0x_frame_reader_if: SPI pin bundle between the frame reader (master) and the converter (slave).
interface ads131a0x_frame_reader_if;
    logic SPI_MISO;
    logic SPI_MOSI;
    logic SPI_SCLK;
    logic SPI_CS;
    modport master(input SPI_MISO, output SPI_MOSI, SPI_SCLK, SPI_CS);
    modport slave(output SPI_MISO, input SPI_MOSI, SPI_SCLK, SPI_CS);
endinterface

// File: rtl/ads131a0x_spi_shifter.sv
// ads131a0x_spi_shifter: SCLK generator (CPOL=0, CPHA=1) shifting FRAME_BITS MISO bits in MSB first.
module ads131a0x_spi_shifter #(
    parameter int FRAME_BITS = 120,
    parameter int SCLK_DIV = 2,
    localparam int BW = $clog2(FRAME_BITS + 1)
) (
    input  logic                  system_clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  sample,
    output logic                  last,
    output logic [BW-1:0]         bit_cnt,
    output logic [FRAME_BITS-1:0] frame
);
    localparam int PW = $clog2(2 * SCLK_DIV);
    logic          active;
    logic [PW-1:0] pos, pos_nxt;
    // pos is the system_clock index inside the current SCLK period; high phase first
    assign pos_nxt = (pos == PW'(2 * SCLK_DIV - 1)) ? '0 : pos + 1'b1;
    assign sample  = active && pos == PW'(SCLK_DIV - 1);
    assign last    = active && pos == PW'(2 * SCLK_DIV - 1) && bit_cnt == BW'(FRAME_BITS);
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            active  <= 1'b0;
            pos     <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            frame   <= '0;
        end else if (start) begin
            active  <= 1'b1;
            pos     <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b1;
        end else if (active) begin
            pos  <= pos_nxt;
            sclk <= !last && pos_nxt < PW'(SCLK_DIV);
            if (sample) begin
                frame   <= {frame[FRAME_BITS-2:0], miso};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (last) active <= 1'b0;
        end
    end
endmodule

// File: rtl/ads131a0x_frame_reader.sv
// ads131a0x_frame_reader: DRDY-triggered ADS131A0x data frame reader with word mapping and overrun count.
// Optional ADS131_CRC_EN: read one extra CRC word per frame and flag mismatches on crc_err.
module ads131a0x_frame_reader import ads131a0x_pkg::*; #(
    parameter int NUM_CH = 4,
    parameter int WORD_BITS = 24,
    parameter int SCLK_DIV = 2,
    parameter int CS_GAP = 4
) (
    input  logic                          system_clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          drdy_n,
    ads131a0x_frame_reader_if.master      spi,
    output logic [15:0]                   status_word,
    output logic [NUM_CH*SAMPLE_BITS-1:0] ch_data,
    output logic                          data_valid,
    output logic                          busy,
    output logic [7:0]                    overrun_cnt
`ifdef ADS131_CRC_EN
    ,
    output logic                          crc_err
`endif
);
`ifdef ADS131_CRC_EN
    localparam int CRC_WORDS = 1;
`else
    localparam int CRC_WORDS = 0;
`endif
    localparam int DATA_BITS = (1 + NUM_CH) * WORD_BITS;
    localparam int FRAME_BITS = DATA_BITS + CRC_WORDS * WORD_BITS;
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(CS_GAP + 1);
    state_t                        state, nxt;
    logic [2:0]                    drdy_sync;
    logic [GW-1:0]                 cnt, gap;
    logic                          drdy_fall, gap_ok, cnt_end, start, capture, cs;
    logic                          sclk, sample, last, unused;
    logic [BW-1:0]                 bit_cnt;
    logic [FRAME_BITS-1:0]         frame;
    logic [NUM_CH*SAMPLE_BITS-1:0] mapped;
    assign drdy_fall = drdy_sync[2] && !drdy_sync[1];
    assign gap_ok    = gap == GW'(CS_GAP);
    assign cnt_end   = cnt == GW'(CS_GAP - 1);
    assign start     = state == CS_SETUP && cnt_end;
    assign capture   = state == CS_HOLD && cnt_end;
    assign spi.SPI_CS   = cs;
    assign spi.SPI_SCLK = sclk;
    assign spi.SPI_MOSI = NULL_CMD[15];
    assign unused = ^{frame, bit_cnt, sample};
    ads131a0x_spi_shifter #(.FRAME_BITS(FRAME_BITS), .SCLK_DIV(SCLK_DIV)) u_shifter (
        .system_clock(system_clock),
        .reset_n(reset_n),
        .start(start),
        .miso(spi.SPI_MISO),
        .sclk(sclk),
        .sample(sample),
        .last(last),
        .bit_cnt(bit_cnt),
        .frame(frame)
    );
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam int HI = FRAME_BITS - 1 - (n + 1) * WORD_BITS;
        if (WORD_BITS >= SAMPLE_BITS) begin : g_top
            assign mapped[n*SAMPLE_BITS +: SAMPLE_BITS] = frame[HI -: SAMPLE_BITS];
        end else begin : g_sext
            assign mapped[n*SAMPLE_BITS +: SAMPLE_BITS] = {{(SAMPLE_BITS - WORD_BITS){frame[HI]}}, frame[HI -: WORD_BITS]};
        end
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = (drdy_fall && enable && gap_ok) ? CS_SETUP : IDLE;
            CS_SETUP: nxt = cnt_end ? SHIFT : CS_SETUP;
            SHIFT:    nxt = last ? CS_HOLD : SHIFT;
            CS_HOLD:  nxt = cnt_end ? DONE : CS_HOLD;
            default:  nxt = IDLE;
        endcase
    end
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= nxt;
    end
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            drdy_sync   <= 3'b111;
            cnt         <= '0;
            gap         <= '0;
            cs          <= 1'b1;
            busy        <= 1'b0;
            overrun_cnt <= '0;
            status_word <= '0;
            ch_data     <= '0;
            data_valid  <= 1'b0;
        end else begin
            drdy_sync  <= {drdy_sync[1:0], drdy_n};
            cnt        <= (nxt != state) ? '0 : cnt + 1'b1;
            gap        <= !cs ? '0 : gap_ok ? gap : gap + 1'b1;
            cs         <= !(nxt inside {CS_SETUP, SHIFT, CS_HOLD});
            busy       <= nxt != IDLE;
            data_valid <= capture;
            // a fall during a frame is only counted, never restarts it
            if (drdy_fall && busy && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 1'b1;
            if (capture) begin
                status_word <= frame[FRAME_BITS-1 -: 16];
                ch_data     <= mapped;
            end
        end
    end
`ifdef ADS131_CRC_EN
    logic [15:0] crc;
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            crc     <= CRC_INIT;
            crc_err <= 1'b0;
        end else begin
            if (start) crc <= CRC_INIT;
            else if (sample && bit_cnt < BW'(DATA_BITS)) crc <= crc_step(crc, spi.SPI_MISO);
            if (capture) crc_err <= crc != frame[WORD_BITS-1 -: 16];
        end
    end
`endif
endmodule

// File: tb/tb_ads131a0x_frame_reader.sv
// tb_ads131a0x_frame_reader: directed frames through 24/16/32-bit readers with MISO models driven by SCLK.
module tb_ads131a0x_frame_reader;
`ifdef ADS131_CRC_EN
    localparam int CW = 1;
`else
    localparam int CW = 0;
`endif
    localparam int D0 = 5 * 24, D1 = 3 * 16, D2 = 3 * 32;
    localparam int F0 = D0 + CW * 24, F1 = D1 + CW * 16, F2 = D2 + CW * 32;
    localparam int L0 = 11 + 4 * F0;
    logic clk = 0, rst_n = 1, en = 1, drdy_a = 1, drdy_b = 1;
    logic m0 = 0, m1 = 0, m2 = 0;
    logic [15:0] st0, st1, st2;
    logic [95:0] ch0;
    logic [47:0] ch1, ch2;
    logic dv0, dv1, dv2, bz0, bz1, bz2;
    logic [7:0] ov0, ov1, ov2;
    logic [F0-1:0] f0;
    logic [F1-1:0] f1;
    logic [F2-1:0] f2;
    logic [159:0] d0a, d0b;
    int i0, i1, i2, r0, cf0, dvc0, cyc;
    int ncmp = 0, nerr = 0;
`ifdef ADS131_CRC_EN
    logic ce0, ce1, ce2;
`endif
    always #5 clk = ~clk;
    ads131a0x_frame_reader_if s0(), s1(), s2();
    assign s0.SPI_MISO = m0;
    assign s1.SPI_MISO = m1;
    assign s2.SPI_MISO = m2;
    ads131a0x_frame_reader #(.NUM_CH(4), .WORD_BITS(24), .SCLK_DIV(2), .CS_GAP(4)) u0 (
        .system_clock(clk), .reset_n(rst_n), .enable(en), .drdy_n(drdy_a), .spi(s0),
        .status_word(st0), .ch_data(ch0), .data_valid(dv0), .busy(bz0), .overrun_cnt(ov0)
`ifdef ADS131_CRC_EN
        , .crc_err(ce0)
`endif
    );
    ads131a0x_frame_reader #(.NUM_CH(2), .WORD_BITS(16), .SCLK_DIV(2), .CS_GAP(4)) u1 (
        .system_clock(clk), .reset_n(rst_n), .enable(1'b1), .drdy_n(drdy_b), .spi(s1),
        .status_word(st1), .ch_data(ch1), .data_valid(dv1), .busy(bz1), .overrun_cnt(ov1)
`ifdef ADS131_CRC_EN
        , .crc_err(ce1)
`endif
    );
    ads131a0x_frame_reader #(.NUM_CH(2), .WORD_BITS(32), .SCLK_DIV(2), .CS_GAP(4)) u2 (
        .system_clock(clk), .reset_n(rst_n), .enable(1'b1), .drdy_n(drdy_b), .spi(s2),
        .status_word(st2), .ch_data(ch2), .data_valid(dv2), .busy(bz2), .overrun_cnt(ov2)
`ifdef ADS131_CRC_EN
        , .crc_err(ce2)
`endif
    );
    // converter models: next bit driven on each SCLK rise while CS is low
    always @(negedge s0.SPI_CS) begin i0 = 0; cf0++; end
    always @(negedge s1.SPI_CS) i1 = 0;
    always @(negedge s2.SPI_CS) i2 = 0;
    always @(posedge s0.SPI_SCLK) if (!s0.SPI_CS) begin m0 = (i0 < F0) ? f0[F0-1-i0] : 1'b0; i0++; r0++; end
    always @(posedge s1.SPI_SCLK) if (!s1.SPI_CS) begin m1 = (i1 < F1) ? f1[F1-1-i1] : 1'b0; i1++; end
    always @(posedge s2.SPI_SCLK) if (!s2.SPI_CS) begin m2 = (i2 < F2) ? f2[F2-1-i2] : 1'b0; i2++; end
    always @(negedge clk) if (dv0) dvc0++;
    function automatic logic [15:0] crc16(input logic [159:0] d, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = n - 1; i >= 0; i--) c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction
    function automatic logic [191:0] mk(input logic [159:0] d, input int n, input int w);
        logic [191:0] r;
        r = 192'(d);
`ifdef ADS131_CRC_EN
        r = (r << w) | (192'(crc16(d, n)) << (w - 16));
`endif
        return r;
    endfunction
    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic fall_a();
        drdy_a = 1;
        repeat (3) @(negedge clk);
        drdy_a = 0;
    endtask
    task automatic wait_dv(input int w, output int c);
        c = 0;
        while (c < 2000) begin
            @(negedge clk);
            c++;
            if ((w == 0 && dv0) || (w == 1 && dv1) || (w == 2 && dv2)) break;
        end
    endtask
    initial begin
        d0a = 160'({24'h2200A5, 24'h7FFFFF, 24'h800000, 24'h000001, 24'h123456});
        d0b = 160'({24'h2201C3, 24'h000000, 24'hFFFFFF, 24'h400000, 24'hABCDEF});
        f0 = F0'(mk(d0a, D0, 24));
        f1 = F1'(mk(160'({16'h22AB, 16'h8001, 16'h7FFF}), D1, 16));
        f2 = F2'(mk(160'({32'h22334455, 32'hABCDEF00, 32'h00000100}), D2, 32));
        #1 rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_cs", s0.SPI_CS, 1);
        chk("rst_sclk", s0.SPI_SCLK, 0);
        chk("rst_mosi", s0.SPI_MOSI, 0);
        chk("rst_status", st0, 0);
        chk("rst_ch", ch0, 0);
        chk("rst_valid", dv0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_ovr", ov0, 0);
        rst_n = 1;
        repeat (6) @(negedge clk);
        // basic 4ch x 24-bit frame
        r0 = 0; cf0 = 0;
        fall_a();
        wait_dv(0, cyc);
        chk("t1_latency_ok", cyc >= L0 && cyc <= L0 + 2, 1);
        chk("t1_status", st0, 16'h2200);
        chk("t1_ch", ch0, {24'h123456, 24'h000001, 24'h800000, 24'h7FFFFF});
        chk("t1_sclk_rises", r0, F0);
        chk("t1_ovr", ov0, 0);
`ifdef ADS131_CRC_EN
        chk("t1_crc_err", ce0, 0);
`endif
        @(negedge clk);
        chk("t1_valid_one_cycle", dv0, 0);
        // 16-bit sign extension and 32-bit truncation
        drdy_b = 1;
        repeat (3) @(negedge clk);
        drdy_b = 0;
        wait_dv(1, cyc);
        chk("t2_w16_seen", cyc < 2000, 1);
        chk("t2_w16_status", st1, 16'h22AB);
        chk("t2_w16_ch", ch1, {24'h007FFF, 24'hFF8001});
        wait_dv(2, cyc);
        chk("t2_w32_seen", cyc < 2000, 1);
        chk("t2_w32_status", st2, 16'h2233);
        chk("t2_w32_ch", ch2, {24'h000001, 24'hABCDEF});
`ifdef ADS131_CRC_EN
        chk("t2_w16_crc_err", ce1, 0);
        chk("t2_w32_crc_err", ce2, 0);
`endif
        // overrun: second fall 50 cycles into SHIFT
        cf0 = 0; dvc0 = 0;
        fall_a();
        repeat (57) @(negedge clk);
        chk("t3_busy_mid", bz0, 1);
        fall_a();
        wait_dv(0, cyc);
        chk("t3_frame_seen", cyc < 2000, 1);
        repeat (30) @(negedge clk);
        chk("t3_ovr", ov0, 1);
        chk("t3_one_valid", dvc0, 1);
        chk("t3_one_cs_fall", cf0, 1);
        // disabled: DRDY ignored and not counted
        en = 0; cf0 = 0;
        fall_a();
        repeat (40) @(negedge clk);
        chk("t4_no_cs", cf0, 0);
        chk("t4_ovr_same", ov0, 1);
        chk("t4_idle", bz0, 0);
        // enable dropped mid-frame: frame still completes
        en = 1;
        f0 = F0'(mk(d0b, D0, 24));
        fall_a();
        repeat (100) @(negedge clk);
        en = 0;
        wait_dv(0, cyc);
        chk("t4_frame_done", cyc < 2000, 1);
        chk("t4_status", st0, 16'h2201);
        chk("t4_ch", ch0, {24'hABCDEF, 24'h400000, 24'hFFFFFF, 24'h000000});
        en = 1;
        // overrun counter saturation
        for (int k = 0; k < 300; k++) begin
            drdy_a = 1;
            repeat (3) @(negedge clk);
            drdy_a = 0;
            repeat (3) @(negedge clk);
        end
        cyc = 0;
        while (bz0 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("t3_idle_after_burst", bz0, 0);
        chk("t3_ovr_sat", ov0, 8'hFF);
        // reset mid-SHIFT aborts immediately
        f0 = F0'(mk(d0a, D0, 24));
        fall_a();
        repeat (57) @(negedge clk);
        rst_n = 0;
        #1;
        chk("t5_cs", s0.SPI_CS, 1);
        chk("t5_sclk", s0.SPI_SCLK, 0);
        chk("t5_busy", bz0, 0);
        chk("t5_status", st0, 0);
        chk("t5_ch", ch0, 0);
        chk("t5_valid", dv0, 0);
        chk("t5_ovr", ov0, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (6) @(negedge clk);
        r0 = 0; cf0 = 0;
        fall_a();
        wait_dv(0, cyc);
        chk("t5_frame_seen", cyc < 2000, 1);
        chk("t5_status_after", st0, 16'h2200);
        chk("t5_ch_after", ch0, {24'h123456, 24'h000001, 24'h800000, 24'h7FFFFF});
        chk("t5_sclk_rises", r0, F0);
        chk("t5_cs_falls", cf0, 1);
`ifdef ADS131_CRC_EN
        // corrupted data bit against an unchanged CRC word
        f0[F0-40] = ~f0[F0-40];
        fall_a();
        wait_dv(0, cyc);
        chk("t6_bad_valid", cyc < 2000, 1);
        chk("t6_bad_crc_err", ce0, 1);
        f0 = F0'(mk(d0b, D0, 24));
        fall_a();
        wait_dv(0, cyc);
        chk("t6_good_valid", cyc < 2000, 1);
        chk("t6_good_crc_err", ce0, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
